// File: rtl/mem_arbiter_if.sv
// Bundle of instruction port, data port and memory port signals for mem_arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  i_req;
    logic [DATA_WIDTH-1:0] i_addr;
    logic                  i_ack;
    logic [DATA_WIDTH-1:0] i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [3:0]            d_be;
    logic [DATA_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_ack;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;
    logic                  err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output busy, err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  busy, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Unified-memory arbiter: data-priority grants with a bounded data streak, req/ack ports.
// Define MEM_ARB_TIMEOUT_EN to abort memory accesses that never see mem_ack.
module mem_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_D_STREAK   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MEM_I = 2'd1;
    localparam logic [1:0] S_MEM_D = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    if (MAX_D_STREAK == 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $fatal(1, "mem_arbiter: MAX_D_STREAK must be >0 and TIMEOUT_CYCLES >= 2");
    end

    logic [1:0]            r_state,     w_state_next;
    logic [SW-1:0]         r_streak,    w_streak_next;
    logic                  r_mem_req,   w_mem_req_next;
    logic                  r_mem_we,    w_mem_we_next;
    logic [3:0]            r_mem_be,    w_mem_be_next;
    logic [DATA_WIDTH-1:0] r_mem_addr,  w_mem_addr_next;
    logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_next;
    logic                  r_i_ack,     w_i_ack_next;
    logic                  r_d_ack,     w_d_ack_next;
    logic [DATA_WIDTH-1:0] r_i_rdata,   w_i_rdata_next;
    logic [DATA_WIDTH-1:0] r_d_rdata,   w_d_rdata_next;
    logic                  w_grant_d;
    logic                  w_in_mem;
    logic                  w_timeout;
    logic                  w_unused_addr_lsb;

    // Address LSBs are dropped: the memory is word-addressed on this side.
    assign w_unused_addr_lsb = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

    assign w_in_mem  = (r_state == S_MEM_I) || (r_state == S_MEM_D);
    assign w_grant_d = bus.d_req && !(bus.i_req && (r_streak == STREAK_MAX));

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_timer;
    logic          r_err, w_err_next;

    assign w_timeout = w_in_mem && (r_timer == TW'(TIMEOUT_CYCLES - 1));

    // Timer is held at zero outside MEM_x, so it starts from zero on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            r_timer <= w_in_mem ? r_timer + TW'(1) : '0;
            r_err   <= w_err_next;
        end
    end

    assign bus.err = r_err;
`else
    assign w_timeout = 1'b0;
    assign bus.err   = 1'b0;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_streak_next    = r_streak;
        w_mem_req_next   = r_mem_req;
        w_mem_we_next    = r_mem_we;
        w_mem_be_next    = r_mem_be;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_i_ack_next     = r_i_ack;
        w_d_ack_next     = r_d_ack;
        w_i_rdata_next   = r_i_rdata;
        w_d_rdata_next   = r_d_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
        w_err_next       = r_err;
`endif

        case (r_state)
            S_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    w_mem_req_next = 1'b1;
                    if (w_grant_d) begin
                        w_state_next     = S_MEM_D;
                        w_mem_addr_next  = {bus.d_addr[DATA_WIDTH-1:2], 2'b00};
                        w_mem_we_next    = bus.d_we;
                        w_mem_be_next    = bus.d_be;
                        w_mem_wdata_next = bus.d_wdata;
                        if (!bus.i_req) begin
                            w_streak_next = '0;
                        end else if (r_streak != STREAK_MAX) begin
                            w_streak_next = r_streak + SW'(1);
                        end
                    end else begin
                        w_state_next    = S_MEM_I;
                        w_mem_addr_next = {bus.i_addr[DATA_WIDTH-1:2], 2'b00};
                        w_mem_we_next   = 1'b0;
                        w_mem_be_next   = 4'hF;
                        w_streak_next   = '0;
                    end
                end
            end

            S_MEM_I, S_MEM_D: begin
                if (bus.mem_ack) begin
                    w_mem_req_next = 1'b0;
                    w_state_next   = S_RESP;
                    if (r_state == S_MEM_I) begin
                        w_i_ack_next   = 1'b1;
                        w_i_rdata_next = bus.mem_rdata;
                    end else begin
                        w_d_ack_next = 1'b1;
                        if (!r_mem_we) begin
                            w_d_rdata_next = bus.mem_rdata;
                        end
                    end
                end else if (w_timeout) begin
                    // Aborted fetch returns a NOP so the core can keep running.
                    w_mem_req_next = 1'b0;
                    w_state_next   = S_RESP;
`ifdef MEM_ARB_TIMEOUT_EN
                    w_err_next     = 1'b1;
`endif
                    if (r_state == S_MEM_I) begin
                        w_i_ack_next   = 1'b1;
                        w_i_rdata_next = DATA_WIDTH'(32'h0000_0013);
                    end else begin
                        w_d_ack_next = 1'b1;
                        if (!r_mem_we) begin
                            w_d_rdata_next = '0;
                        end
                    end
                end
            end

            default: begin
                w_i_ack_next = 1'b0;
                w_d_ack_next = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                w_err_next   = 1'b0;
`endif
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_streak    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'h0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_streak    <= w_streak_next;
            r_mem_req   <= w_mem_req_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_be    <= w_mem_be_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_i_ack     <= w_i_ack_next;
            r_d_ack     <= w_d_ack_next;
            r_i_rdata   <= w_i_rdata_next;
            r_d_rdata   <= w_d_rdata_next;
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.i_ack     = r_i_ack;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_ack     = r_d_ack;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the timeout case runs only when
// MEM_ARB_TIMEOUT_EN is defined for the build.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if #(.DATA_WIDTH(32)) bus ();

    mem_arbiter #(
        .DATA_WIDTH    (32),
        .MAX_D_STREAK  (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold mem_ack low for wait_cycles edges, then return rdata for one cycle.
    task automatic mem_reply(input int wait_cycles, input logic [31:0] rdata);
        bus.mem_ack = 1'b0;
        repeat (wait_cycles) tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.i_req     = 1'b0;
        bus.i_addr    = 32'h0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_be      = 4'h0;
        bus.d_addr    = 32'h0;
        bus.d_wdata   = 32'h0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        #12;

        check("rst mem_req", 32'(bus.mem_req), 32'h0);
        check("rst busy",    32'(bus.busy),    32'h0);
        check("rst i_ack",   32'(bus.i_ack),   32'h0);
        check("rst d_ack",   32'(bus.d_ack),   32'h0);
        check("rst err",     32'(bus.err),     32'h0);
        check("rst i_rdata", bus.i_rdata,      32'h0);
        check("rst d_rdata", bus.d_rdata,      32'h0);
        check("rst mem_addr", bus.mem_addr,    32'h0);
        rst = 1'b0;

        // Single fetch.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0;
        tick();
        check("f1 mem_req",  32'(bus.mem_req), 32'h1);
        check("f1 mem_addr", bus.mem_addr,     32'h0);
        check("f1 mem_be",   32'(bus.mem_be),  32'hF);
        check("f1 mem_we",   32'(bus.mem_we),  32'h0);
        check("f1 busy",     32'(bus.busy),    32'h1);
        mem_reply(1, 32'h0050_0093);
        check("f1 i_ack",    32'(bus.i_ack),   32'h1);
        check("f1 d_ack",    32'(bus.d_ack),   32'h0);
        check("f1 i_rdata",  bus.i_rdata,      32'h0050_0093);
        check("f1 mem_req drop", 32'(bus.mem_req), 32'h0);
        check("f1 err",      32'(bus.err),     32'h0);
        bus.i_req = 1'b0;
        tick();
        check("f1 i_ack end", 32'(bus.i_ack),  32'h0);
        check("f1 busy end",  32'(bus.busy),   32'h0);
        check("f1 i_rdata hold", bus.i_rdata,  32'h0050_0093);

        // Simultaneous requests: data first, then instruction.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h8;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_be   = 4'hF;
        bus.d_addr = 32'h104;
        tick();
        check("c1 mem_addr", bus.mem_addr,    32'h104);
        check("c1 mem_we",   32'(bus.mem_we), 32'h0);
        mem_reply(0, 32'hCAFE_0001);
        check("c1 d_ack",    32'(bus.d_ack),  32'h1);
        check("c1 i_ack",    32'(bus.i_ack),  32'h0);
        check("c1 d_rdata",  bus.d_rdata,     32'hCAFE_0001);
        bus.d_req = 1'b0;
        tick();
        check("c1 d_ack end", 32'(bus.d_ack), 32'h0);
        tick();
        check("c2 mem_addr", bus.mem_addr,    32'h8);
        check("c2 mem_be",   32'(bus.mem_be), 32'hF);
        mem_reply(0, 32'h0000_0033);
        check("c2 i_ack",    32'(bus.i_ack),  32'h1);
        check("c2 i_rdata",  bus.i_rdata,     32'h0000_0033);
        bus.i_req = 1'b0;
        tick();

        // Streak limit: four stores win, then the held fetch is forced through.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h10;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b1;
        bus.d_be   = 4'hF;
        for (int g = 0; g < 5; g++) begin
            bus.d_addr  = 32'h400 + 32'(4 * g);
            bus.d_wdata = 32'h1000 + 32'(g);
            tick();
            check("s grant we", 32'(bus.mem_we), (g < 4) ? 32'h1 : 32'h0);
            check("s grant addr", bus.mem_addr, (g < 4) ? 32'h400 + 32'(4 * g) : 32'h10);
            if (g < 4) check("s mem_wdata", bus.mem_wdata, 32'h1000 + 32'(g));
            check("s streak", 32'(dut.r_streak), (g < 4) ? 32'(g + 1) : 32'h0);
            mem_reply(0, 32'h0000_0100 + 32'(g));
            check("s d_ack", 32'(bus.d_ack), (g < 4) ? 32'h1 : 32'h0);
            check("s i_ack", 32'(bus.i_ack), (g < 4) ? 32'h0 : 32'h1);
            tick();
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        check("s d_rdata kept", bus.d_rdata, 32'hCAFE_0001);
        check("s i_rdata",      bus.i_rdata, 32'h0000_0104);

        // Unaligned byte-masked store.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_be    = 4'b0011;
        bus.d_addr  = 32'h203;
        bus.d_wdata = 32'hDEAD_BEEF;
        tick();
        check("st mem_addr",  bus.mem_addr,     32'h200);
        check("st mem_we",    32'(bus.mem_we),  32'h1);
        check("st mem_be",    32'(bus.mem_be),  32'h3);
        check("st mem_wdata", bus.mem_wdata,    32'hDEAD_BEEF);
        mem_reply(2, 32'h1234_5678);
        check("st d_ack",     32'(bus.d_ack),   32'h1);
        check("st d_rdata",   bus.d_rdata,      32'hCAFE_0001);
        bus.d_req = 1'b0;
        tick();

        // Fetch request withdrawn mid-access still completes.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h24;
        tick();
        bus.i_req = 1'b0;
        mem_reply(1, 32'hABCD_0000);
        check("dr i_ack",   32'(bus.i_ack), 32'h1);
        check("dr i_rdata", bus.i_rdata,    32'hABCD_0000);
        tick();

        // Stray mem_ack in IDLE is ignored.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.mem_ack   = 1'b0;
        check("ia busy",    32'(bus.busy),  32'h0);
        check("ia i_ack",   32'(bus.i_ack), 32'h0);
        check("ia d_ack",   32'(bus.d_ack), 32'h0);
        check("ia i_rdata", bus.i_rdata,    32'hABCD_0000);

        // Asynchronous reset during MEM_D.
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_be   = 4'hF;
        bus.d_addr = 32'h300;
        tick();
        check("ar mem_req pre", 32'(bus.mem_req), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("ar mem_req", 32'(bus.mem_req), 32'h0);
        check("ar busy",    32'(bus.busy),    32'h0);
        check("ar d_ack",   32'(bus.d_ack),   32'h0);
        check("ar d_rdata", bus.d_rdata,      32'h0);
        check("ar streak",  32'(dut.r_streak), 32'h0);
        bus.d_req = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h40;
        tick();
        check("ar2 mem_addr", bus.mem_addr,   32'h40);
        check("ar2 d_ack",    32'(bus.d_ack), 32'h0);
        mem_reply(0, 32'h0BAD_F00D);
        check("ar2 i_ack",    32'(bus.i_ack), 32'h1);
        check("ar2 i_rdata",  bus.i_rdata,    32'h0BAD_F00D);
        bus.i_req = 1'b0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Fetch that never gets mem_ack is aborted after 64 cycles in MEM_I.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h80;
        tick();
        repeat (63) tick();
        check("to busy pre",    32'(bus.busy),    32'h1);
        check("to mem_req pre", 32'(bus.mem_req), 32'h1);
        check("to i_ack pre",   32'(bus.i_ack),   32'h0);
        tick();
        check("to i_ack",   32'(bus.i_ack),   32'h1);
        check("to err",     32'(bus.err),     32'h1);
        check("to i_rdata", bus.i_rdata,      32'h0000_0013);
        check("to mem_req", 32'(bus.mem_req), 32'h0);
        bus.i_req = 1'b0;
        tick();
        check("to err end",  32'(bus.err),  32'h0);
        check("to busy end", 32'(bus.busy), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sequences a single-port unified memory between the fetch stage (instruction reads) and the execute stage (data loads/stores) for the multi-cycle variant of the core. Each port uses a req/ack handshake. The arbiter grants data accesses with priority, bounds instruction starvation with a streak counter, and drives a variable-latency memory port. `busy` feeds the core's stall logic.

Parameters:
- DATA_WIDTH, 32, width of address, data and read-data buses.
- MAX_D_STREAK, 4, maximum consecutive data grants while i_req is pending before the instruction port is forced to win.
- TIMEOUT_CYCLES, 64, cycles in a memory state without mem_ack before abort (only with MEM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction read request; held until i_ack.
- i_addr  in  DATA_WIDTH  instruction byte address.
- i_ack  out  1  one-cycle completion pulse for the instruction port.
- i_rdata  out  DATA_WIDTH  fetched word; valid with i_ack, held until the next i_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  byte enables for stores.
- d_addr  in  DATA_WIDTH  data byte address.
- d_wdata  in  DATA_WIDTH  store data.
- d_ack  out  1  one-cycle completion pulse for the data port.
- d_rdata  out  DATA_WIDTH  load word; updated only on load acks.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_addr  out  DATA_WIDTH  word-aligned address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  memory read data.
- busy  out  1  high whenever state != IDLE.
- err  out  1  timeout pulse; tied 0 without MEM_ARB_TIMEOUT_EN.

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, streak counter 0, i_rdata and d_rdata 0. Reset takes effect immediately, including mid-transaction. The open access is abandoned and no ack is issued.
- States: IDLE, MEM_I, MEM_D, RESP.
- IDLE, winner selection: on a clock edge with any request pending, pick a winner. Data wins unless i_req=1 and streak==MAX_D_STREAK.
- IDLE, register outputs: register mem_req=1. mem_addr = winner address with [1:0] forced to 0.
  - Instruction winner: mem_we=0, mem_be=4'hF.
  - Data winner: mem_we=d_we, mem_be=d_be, mem_wdata=d_wdata.
  - Go to MEM_I or MEM_D.
- Streak counter:
  - Increments on a data grant while i_req=1; saturates at MAX_D_STREAK.
  - Clears on an instruction grant, or on a data grant with i_req=0.
- MEM_x: all mem_* outputs stay stable. On mem_ack:
  - mem_req<=0.
  - x_ack<=1.
  - Capture mem_rdata into i_rdata (instruction), or into d_rdata (data loads only; stores leave d_rdata unchanged).
  - Go to RESP.
- RESP: the ack is high for exactly this cycle. Requests are not sampled in RESP. Next state is IDLE.
- Latency and throughput: mem_req rises 1 cycle after req is seen in IDLE. Ack arrives 1 cycle after mem_ack. Minimum 3 cycles per access.
- Requester rules: keep req and fields stable until ack. A new request may be presented from the cycle after ack.
- Requester drops req while in MEM_x: the access still completes and the ack still pulses (defined behaviour for a protocol violation).
- mem_ack in IDLE or RESP: ignored.
- busy: combinational from state.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Enabled: a cycle counter runs in MEM_x and clears on state entry. On reaching TIMEOUT_CYCLES without mem_ack, the arbiter:
  - drops mem_req;
  - enters RESP with x_ack=1 and err=1 for that one cycle;
  - returns i_rdata=32'h00000013 (NOP) for an instruction abort, or d_rdata=0 for a data-load abort.
- Disabled: the arbiter waits indefinitely for mem_ack; err is constant 0 and no counter logic exists.

Test Plan:
- Single fetch, i_addr=0x0, mem_ack 2 cycles after mem_req, mem_rdata=0x00500093 -> mem_req high from cycle 1, mem_addr=0x0, mem_be=F; i_ack one cycle with i_rdata=0x00500093; busy low afterwards.
- i_req (0x8) and d_req load (0x104) both rise in the same cycle -> data granted first (mem_addr=0x104, mem_we=0), d_ack; instruction granted next, i_ack.
- d_req held continuously with new stores, i_req held, MAX_D_STREAK=4 -> exactly 4 data grants, then an instruction grant, then the streak counter reads 0.
- Store d_addr=0x203, d_be=4'b0011, d_wdata=0xDEADBEEF -> mem_addr=0x200, mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; d_ack pulses; d_rdata unchanged.
- rst asserted during MEM_D -> mem_req and busy drop without waiting for a clock edge; no d_ack; after release, a new i_req is served normally.
- MEM_ARB_TIMEOUT_EN, mem_ack never asserted, i_req -> after 64 cycles in MEM_I: i_ack=1, err=1, i_rdata=0x00000013; state returns to IDLE.
